// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: switch/button inputs in, count and flags out.
interface down_timer_if #(
   parameter int WIDTH = 4
);
   logic             set;
   logic             start;
   logic             pause;
   logic [WIDTH-1:0] init;
   logic [WIDTH-1:0] out;
   logic             running;
   logic             done;
   logic             done_pulse;

   modport master (
      output set, start, pause, init,
      input  out, running, done, done_pulse
   );

   modport slave (
      input  set, start, pause, init,
      output out, running, done, done_pulse
   );
endinterface

// File: rtl/down_timer.sv
// Loadable countdown timer with prescaled tick, pause, terminal-count flags and
// optional auto-reload.
module down_timer #(
   parameter int WIDTH       = 4,
   parameter int TICK_DIV    = 50000000,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   down_timer_if.slave  bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state,      w_state_nxt;
   logic [WIDTH-1:0] r_count,      w_count_nxt;
   logic [PW-1:0]    r_presc,      w_presc_nxt;
   logic             r_done_pulse, w_done_pulse_nxt;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_presc      <= '0;
         r_done_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_presc      <= w_presc_nxt;
         r_done_pulse <= w_done_pulse_nxt;
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_count_nxt      = r_count;
      w_presc_nxt      = r_presc;
      w_done_pulse_nxt = 1'b0;

      if (bus.set) begin
         w_count_nxt = bus.init;
         w_presc_nxt = '0;
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && (r_count != '0)) begin
                  w_state_nxt = S_RUN;
                  w_presc_nxt = '0;
               end
            end
            S_RUN: begin
               if (bus.pause) begin
                  w_state_nxt = S_PAUSE;
               end else if (r_presc == TICK_LAST) begin
                  w_presc_nxt = '0;
                  if (r_count > WIDTH'(1)) begin
                     w_count_nxt = r_count - WIDTH'(1);
                  end else begin
                     // Terminal count; a zero count here is treated the same way.
                     w_done_pulse_nxt = (r_count == WIDTH'(1));
                     if (AUTO_RELOAD && (bus.init != '0)) begin
                        w_count_nxt = bus.init;
                     end else begin
                        w_count_nxt = '0;
                        w_state_nxt = S_DONE;
                     end
                  end
               end else begin
                  w_presc_nxt = r_presc + PW'(1);
               end
            end
            S_PAUSE: begin
               if (!bus.pause) begin
                  w_state_nxt = S_RUN;
               end
            end
            S_DONE: begin
               if (bus.start && (bus.init != '0)) begin
                  w_count_nxt = bus.init;
                  w_presc_nxt = '0;
                  w_state_nxt = S_RUN;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign bus.out        = r_count;
   assign bus.running    = (r_state == S_RUN);
   assign bus.done       = (r_state == S_DONE);
   assign bus.done_pulse = r_done_pulse;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: one instance without and one with auto-reload.
module tb_down_timer;

   localparam int WIDTH    = 4;
   localparam int TICK_DIV = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   down_timer_if #(.WIDTH(WIDTH)) bus0 ();
   down_timer_if #(.WIDTH(WIDTH)) bus1 ();

   down_timer #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .AUTO_RELOAD(1'b0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   down_timer #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .AUTO_RELOAD(1'b1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Advance n clock edges; outputs are sampled 1 time unit after each edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus0.set = 1'b0; bus0.start = 1'b0; bus0.pause = 1'b0; bus0.init = '0;
      bus1.set = 1'b0; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.init = '0;
      cyc(2);
      check("rst_out",     bus0.out, 0);
      check("rst_running", bus0.running, 0);
      check("rst_done",    bus0.done, 0);
      check("rst_pulse",   bus0.done_pulse, 0);
      reset = 1'b0;
      cyc(1);

      // Reset mid-run
      bus0.init = 4'd5; bus0.set = 1'b1;
      cyc(1);
      check("mr_load", bus0.out, 5);
      bus0.set = 1'b0; bus0.start = 1'b1;
      cyc(1);
      check("mr_run", bus0.running, 1);
      bus0.start = 1'b0;
      cyc(6);
      check("mr_out4", bus0.out, 4);
      reset = 1'b1;
      #2;
      check("mr_async_out",     bus0.out, 0);
      check("mr_async_running", bus0.running, 0);
      check("mr_async_done",    bus0.done, 0);
      reset = 1'b0;
      cyc(3);
      check("mr_idle_running", bus0.running, 0);
      check("mr_idle_out",     bus0.out, 0);

      // Basic countdown 3,2,1,0
      bus0.init = 4'd3; bus0.set = 1'b1;
      cyc(1);
      check("bc_load", bus0.out, 3);
      bus0.set = 1'b0; bus0.start = 1'b1;
      cyc(1);
      check("bc_run", bus0.running, 1);
      bus0.start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cyc(3);
         check("bc_hold", bus0.out, 4 - k);
         check("bc_hold_pulse", bus0.done_pulse, 0);
         cyc(1);
         check("bc_tick", bus0.out, 3 - k);
         check("bc_tick_pulse", bus0.done_pulse, (k == 3) ? 1 : 0);
      end
      check("bc_done", bus0.done, 1);
      check("bc_running", bus0.running, 0);
      cyc(1);
      check("bc_pulse_drop", bus0.done_pulse, 0);
      cyc(5);
      check("bc_done_hold", bus0.done, 1);
      check("bc_out_hold",  bus0.out, 0);

      // DONE with init=0: start ignored
      bus0.init = 4'd0; bus0.start = 1'b1;
      cyc(2);
      check("z_done_stay",    bus0.done, 1);
      check("z_done_running", bus0.running, 0);

      // DONE with init=3: restart, then set+start priority at out=2
      bus0.init = 4'd3;
      cyc(1);
      check("rs_out",     bus0.out, 3);
      check("rs_running", bus0.running, 1);
      check("rs_done",    bus0.done, 0);
      bus0.start = 1'b0;
      cyc(4);
      check("sp_pre", bus0.out, 2);
      bus0.init = 4'd9; bus0.set = 1'b1; bus0.start = 1'b1;
      cyc(1);
      check("sp_out",     bus0.out, 9);
      check("sp_running", bus0.running, 0);
      check("sp_done",    bus0.done, 0);
      bus0.set = 1'b0;
      cyc(1);
      check("sp_restart", bus0.running, 1);
      bus0.start = 1'b0;
      cyc(4);
      check("sp_tick", bus0.out, 8);

      // Pause: hold 10 cycles after 2 prescaler cycles
      bus0.init = 4'd4; bus0.set = 1'b1;
      cyc(1);
      bus0.set = 1'b0; bus0.start = 1'b1;
      cyc(1);
      bus0.start = 1'b0;
      cyc(2);
      bus0.pause = 1'b1;
      cyc(1);
      check("pa_running", bus0.running, 0);
      cyc(9);
      check("pa_frozen", bus0.out, 4);
      bus0.pause = 1'b0;
      cyc(1);
      check("pa_resume", bus0.running, 1);
      check("pa_resume_out", bus0.out, 4);
      cyc(1);
      check("pa_not_yet", bus0.out, 4);
      cyc(1);
      check("pa_first_dec", bus0.out, 3);
      cyc(11);
      check("pa_one", bus0.out, 1);
      check("pa_not_done", bus0.done, 0);
      cyc(1);
      check("pa_zero",  bus0.out, 0);
      check("pa_pulse", bus0.done_pulse, 1);
      check("pa_done",  bus0.done, 1);

      // Zero load: start ignored in IDLE
      bus0.init = 4'd0; bus0.set = 1'b1;
      cyc(1);
      check("zl_out",  bus0.out, 0);
      check("zl_done", bus0.done, 0);
      bus0.set = 1'b0; bus0.start = 1'b1;
      cyc(2);
      check("zl_running", bus0.running, 0);
      check("zl_done2",   bus0.done, 0);
      check("zl_pulse",   bus0.done_pulse, 0);
      bus0.start = 1'b0;

      // Auto-reload 2,1,2,1,2 then init=0 ends in DONE
      bus1.init = 4'd2; bus1.set = 1'b1;
      cyc(1);
      bus1.set = 1'b0; bus1.start = 1'b1;
      cyc(1);
      check("ar_run", bus1.running, 1);
      check("ar_out2", bus1.out, 2);
      bus1.start = 1'b0;
      for (int r = 0; r < 2; r++) begin
         cyc(4);
         check("ar_out1", bus1.out, 1);
         check("ar_no_pulse", bus1.done_pulse, 0);
         cyc(4);
         check("ar_reload", bus1.out, 2);
         check("ar_pulse", bus1.done_pulse, 1);
         check("ar_running", bus1.running, 1);
         check("ar_not_done", bus1.done, 0);
      end
      cyc(4);
      check("ar_last1", bus1.out, 1);
      bus1.init = 4'd0;
      cyc(4);
      check("ar0_out",     bus1.out, 0);
      check("ar0_pulse",   bus1.done_pulse, 1);
      check("ar0_done",    bus1.done, 1);
      check("ar0_running", bus1.running, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable 4-bit countdown timer. It is the counterpart to the free-running up-counter already on the board.
- It is preloaded from switches, counts down once per prescaled tick, and flags terminal count so downstream LED/alarm logic can react.
- It sits between the switch/button inputs and the LED/7-segment display path.
- It can run continuously with AUTO_RELOAD.

Parameters:
- WIDTH, 4, width of count value and init.
- TICK_DIV, 50000000, clk cycles per count tick (use 4 in simulation); must be >= 2.
- AUTO_RELOAD, 0, when 1 the timer reloads init at terminal count and keeps running.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high; clears all state.
- set, input, 1, synchronous load of init into count; aborts any run.
- init, input, WIDTH, load value; sampled on set, and on auto-reload.
- start, input, 1, level; begins or resumes a countdown from IDLE or DONE.
- pause, input, 1, level; freezes countdown while high.
- out, output, WIDTH, current count value.
- running, output, 1, high in RUN state only.
- done, output, 1, high in DONE state (level).
- done_pulse, output, 1, one-cycle pulse on every terminal count.

Behaviour:
- Reset (async, reset=1):
  - out=0, state=IDLE, prescaler=0, running=0, done=0, done_pulse=0.
  - This holds immediately and regardless of clk, including mid-run.
- States are IDLE, RUN, PAUSE and DONE. done_pulse defaults to 0 every cycle.
- Priority on each posedge: set > start > pause > tick.
- set=1, any state:
  - out<=init, prescaler<=0, state<=IDLE, done<=0.
  - start is ignored in the same cycle.
- IDLE:
  - start=1 and out!=0: state<=RUN, prescaler<=0.
  - start=1 and out==0: ignored, stay IDLE.
  - pause has no effect.
- RUN, pause=1: state<=PAUSE; prescaler and out hold.
- RUN, pause=0:
  - prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler<=0 and a tick occurs. The first tick lands exactly TICK_DIV cycles after entering RUN.
- Tick with out>1: out<=out-1.
- Tick with out==1 (terminal count):
  - done_pulse<=1 for one cycle.
  - AUTO_RELOAD=0: out<=0, state<=DONE.
  - AUTO_RELOAD=1 and init!=0: out<=init, stay RUN.
  - AUTO_RELOAD=1 and init==0: out<=0, state<=DONE.
- PAUSE:
  - pause=0: state<=RUN, resuming with the preserved prescaler value, so no tick is lost or duplicated.
  - start has no effect.
- DONE:
  - done=1, out==0; holds indefinitely.
  - start=1 with init!=0: out<=init, prescaler<=0, state<=RUN, done<=0.
  - start=1 with init==0: stay DONE.
- No wrap-around: out never decrements below 0 and never underflows to all-ones.
- All outputs are registered. running and done reflect the state register, so they change one cycle after the triggering input edge.
- Uncovered states decode to IDLE.

Test Plan:
- Reset mid-run: TICK_DIV=4, init=5, set, start; after 6 cycles assert reset -> out=0, running=0, done=0 immediately (before next clk edge); after release, stays IDLE with start=0.
- Basic countdown: init=3, set, start -> out goes 3,2,1,0 with ticks every 4 cycles, the first 4 cycles after RUN entry; done_pulse high exactly one cycle coincident with out becoming 0; done=1 held; running=0.
- Pause: init=4, running; pause=1 for 10 cycles after the 2nd prescaler cycle -> out frozen at 4; after release, the first decrement arrives 2 cycles later; total run time = 16+10 cycles.
- Set priority: during RUN at out=2, assert set and start together with init=9 -> out=9, state IDLE, running=0 next cycle; start alone then restarts.
- Zero handling: init=0, set, start -> stays IDLE, done=0, no done_pulse. From DONE with init=0, start -> remains DONE.
- Auto-reload: AUTO_RELOAD=1, init=2, start -> out sequence 2,1,2,1,2 with done_pulse on each 1->2 transition; running stays 1; done stays 0.
